// File: rtl/rice_core_muldiv.sv
// rtl/rice_core_muldiv.sv - iterative RISC-V M-extension multiply/divide unit
// Shift-add multiply and restoring divide, one bit per cycle; divide special cases finish in one cycle.

package rice_core_pkg;
   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } rice_core_muldiv_command;
endpackage

module rice_core_muldiv #(
   parameter int XLEN = 32
) (
   input  logic                                   i_clk,
   input  logic                                   i_rst_n,
   input  logic                                   i_flush,
   input  logic                                   i_valid,
   output logic                                   o_ready,
   input  rice_core_pkg::rice_core_muldiv_command i_command,
   input  logic [XLEN-1:0]                        i_rs1_value,
   input  logic [XLEN-1:0]                        i_rs2_value,
   output logic                                   o_valid,
   input  logic                                   i_ready,
   output logic [XLEN-1:0]                        o_result
);
   import rice_core_pkg::*;

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]              state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   rice_core_muldiv_command cmd_q, cmd_d;
   logic                    neg_q, neg_d;
   logic [XLEN-1:0]         opa_q, opa_d;
   logic [2*XLEN-1:0]       acc_q, acc_d;
   logic [XLEN-1:0]         result_q, result_d;

   rice_core_muldiv_command cmd_in;
   logic                    rs1_signed, rs2_signed, rs1_neg, rs2_neg;
   logic                    in_is_div, in_is_rem, div_by_zero, div_overflow;
   logic [XLEN-1:0]         mag1, mag2, special_val;
   logic                    q_is_div;
   logic [XLEN:0]           mul_sum, div_trial;
   logic [2*XLEN-1:0]       mul_next, div_next, step, prod;
   logic [XLEN-1:0]         quo, rem, final_val;

   always_comb begin
      case (i_command)
         MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU: cmd_in = i_command;
         default:                                        cmd_in = MUL;
      endcase
      rs1_signed   = (cmd_in == MULH) || (cmd_in == MULHSU) || (cmd_in == DIV) || (cmd_in == REM);
      rs2_signed   = (cmd_in == MULH) || (cmd_in == DIV) || (cmd_in == REM);
      rs1_neg      = rs1_signed && i_rs1_value[XLEN-1];
      rs2_neg      = rs2_signed && i_rs2_value[XLEN-1];
      mag1         = rs1_neg ? (~i_rs1_value + 1'b1) : i_rs1_value;
      mag2         = rs2_neg ? (~i_rs2_value + 1'b1) : i_rs2_value;
      in_is_div    = (cmd_in == DIV) || (cmd_in == DIVU) || (cmd_in == REM) || (cmd_in == REMU);
      in_is_rem    = (cmd_in == REM) || (cmd_in == REMU);
      div_by_zero  = in_is_div && (i_rs2_value == '0);
      div_overflow = ((cmd_in == DIV) || (cmd_in == REM)) && (i_rs1_value == MIN_NEG)
                     && (i_rs2_value == '1);
      if (div_by_zero)
         special_val = in_is_rem ? i_rs1_value : '1;
      else
         special_val = in_is_rem ? '0 : i_rs1_value;
   end

   // Multiply keeps {partial product, remaining multiplier bits}; divide keeps {remainder, dividend/quotient}.
   always_comb begin
      q_is_div  = (cmd_q == DIV) || (cmd_q == DIVU) || (cmd_q == REM) || (cmd_q == REMU);
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
      mul_next  = {mul_sum, acc_q[XLEN-1:1]};
      div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opa_q};
      div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                  : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      step      = q_is_div ? div_next : mul_next;
      prod      = neg_q ? (~step + 1'b1) : step;
      quo       = neg_q ? (~step[XLEN-1:0] + 1'b1) : step[XLEN-1:0];
      rem       = neg_q ? (~step[2*XLEN-1:XLEN] + 1'b1) : step[2*XLEN-1:XLEN];
      case (cmd_q)
         MULH, MULHSU, MULHU: final_val = prod[2*XLEN-1:XLEN];
         DIV, DIVU:           final_val = quo;
         REM, REMU:           final_val = rem;
         default:             final_val = prod[XLEN-1:0];
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cmd_d    = cmd_q;
      neg_d    = neg_q;
      opa_d    = opa_q;
      acc_d    = acc_q;
      result_d = result_q;
      if (i_flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_valid) begin
                  cmd_d = cmd_in;
                  cnt_d = '0;
                  neg_d = in_is_rem ? rs1_neg : (rs1_neg ^ rs2_neg);
                  opa_d = in_is_div ? mag2 : mag1;
                  acc_d = {{XLEN{1'b0}}, (in_is_div ? mag1 : mag2)};
                  if (div_by_zero || div_overflow) begin
                     result_d = special_val;
                     state_d  = S_DONE;
                  end else begin
                     state_d = S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               acc_d = step;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(XLEN-1)) begin
                  result_d = final_val;
                  state_d  = S_DONE;
               end
            end
            S_DONE: begin
               if (i_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         cmd_q    <= MUL;
         neg_q    <= 1'b0;
         opa_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cmd_q    <= cmd_d;
         neg_q    <= neg_d;
         opa_q    <= opa_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   assign o_ready  = (state_q == S_IDLE);
   assign o_valid  = (state_q == S_DONE);
   assign o_result = result_q;

endmodule
